mul_issue_sequencer: RTL and testbench

Operand front-end and result back-end for the iterative 32-cycle Booth multiplier core.
- Accepts operand pairs on a valid/ready stream and buffers them in a small FIFO.
- Launches one multiplication at a time and holds the operands stable for the core's full iteration.
- Captures the 64-bit product after a fixed latency and presents it on a valid/ready output stream.
- Sits between the issuing datapath and the multiplier core.

---
 rtl/mul_issue_sequencer.sv | 143 ++++++++++++++
 tb/tb_mul_issue_sequencer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/mul_issue_sequencer.sv
// Operand FIFO, launch and capture sequencer around the iterative multiplier core.
// States: S_IDLE (nothing in flight) | S_WAIT (core iterating) | S_HOLD (product awaiting consumer)
module mul_issue_sequencer #(
  parameter int WIDTH       = 32,
  parameter int DEPTH       = 4,
  parameter int MUL_LATENCY = 33
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_a,
  input  logic [WIDTH-1:0]           in_b,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [2*WIDTH-1:0]         out_product,
  output logic                       mul_start,
  output logic [WIDTH-1:0]           mul_a,
  output logic [WIDTH-1:0]           mul_b,
  input  logic [2*WIDTH-1:0]         mul_result,
  output logic                       busy,
  output logic [$clog2(DEPTH):0]     fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(MUL_LATENCY);
  localparam logic [LW-1:0] CNT_LOAD = LW'(MUL_LATENCY - 1);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD} state_t;

  state_t             r_state, w_state_nxt;
  logic [LW-1:0]      r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0]   r_mem_a [DEPTH];
  logic [WIDTH-1:0]   r_mem_b [DEPTH];
  logic [AW-1:0]      r_wr_ptr, r_rd_ptr;
  logic [AW:0]        r_count;
  logic               r_mul_start;
  logic [WIDTH-1:0]   r_mul_a, r_mul_b;
  logic               r_out_valid;
  logic [2*WIDTH-1:0] r_out_product;
  logic               w_push, w_launch, w_capture, w_consume;

  // in_ready looks only at the registered count, so a same-cycle pop never frees space
  assign in_ready = (r_count < FULL_CNT);
  assign w_push   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_a[r_wr_ptr] <= in_a;
      r_mem_b[r_wr_ptr] <= in_b;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push)   r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_launch) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_launch})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_launch    = 1'b0;
    w_capture   = 1'b0;
    w_consume   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_count != '0) begin
          w_launch    = 1'b1;
          w_cnt_nxt   = CNT_LOAD;
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (r_cnt == '0) begin
          w_capture   = 1'b1;
          w_state_nxt = S_HOLD;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      S_HOLD: begin
        if (out_ready) begin
          w_consume = 1'b1;
          if (r_count != '0) begin
            w_launch    = 1'b1;
            w_cnt_nxt   = CNT_LOAD;
            w_state_nxt = S_WAIT;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_mul_start   <= 1'b0;
      r_mul_a       <= '0;
      r_mul_b       <= '0;
      r_out_valid   <= 1'b0;
      r_out_product <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_mul_start <= w_launch;
      if (w_launch) begin
        r_mul_a <= r_mem_a[r_rd_ptr];
        r_mul_b <= r_mem_b[r_rd_ptr];
      end
      if (w_capture) begin
        r_out_valid   <= 1'b1;
        r_out_product <= mul_result;
      end else if (w_consume) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign mul_start   = r_mul_start;
  assign mul_a       = r_mul_a;
  assign mul_b       = r_mul_b;
  assign out_valid   = r_out_valid;
  assign out_product = r_out_product;
  assign busy        = (r_state != S_IDLE);
  assign fifo_count  = r_count;

endmodule

// File: tb/tb_mul_issue_sequencer.sv
// Randomised and directed bench for mul_issue_sequencer against a timestamp/queue model.
module tb_mul_issue_sequencer;
  localparam int W = 32;
  localparam int D = 4;
  localparam int L = 33;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_a = '0, in_b = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [2*W-1:0] out_product;
  logic          mul_start;
  logic [W-1:0]  mul_a, mul_b;
  logic [2*W-1:0] mul_result = '0;
  logic          busy;
  logic [$clog2(D):0] fifo_count;

  mul_issue_sequencer #(.WIDTH(W), .DEPTH(D), .MUL_LATENCY(L)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
    .out_product(out_product), .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
    .mul_result(mul_result), .busy(busy), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: pending operand queue, one in-flight op with its launch edge, one held product
  logic [W-1:0] q_a[$];
  logic [W-1:0] q_b[$];
  bit           m_fly, m_hold, m_start;
  longint       m_launch;
  longint       edge_n = 0;
  logic [W-1:0] m_a, m_b;
  logic [63:0]  m_prod;
  bit           last_acc;

  function automatic logic [63:0] prod(input logic [W-1:0] a, input logic [W-1:0] b);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    return p;
  endfunction

  task automatic model_reset();
    q_a.delete(); q_b.delete();
    m_fly = 0; m_hold = 0; m_start = 0;
    m_a = '0; m_b = '0; m_prod = '0; m_launch = 0;
  endtask

  task automatic check_outputs(input string ph);
    chk({ph, ":in_ready"},   64'(in_ready),   64'(q_a.size() < D));
    chk({ph, ":fifo_count"}, 64'(fifo_count), 64'(q_a.size()));
    chk({ph, ":mul_start"},  64'(mul_start),  64'(m_start));
    chk({ph, ":mul_a"},      64'(mul_a),      64'(m_a));
    chk({ph, ":mul_b"},      64'(mul_b),      64'(m_b));
    chk({ph, ":busy"},       64'(busy),       64'(m_fly || m_hold));
    chk({ph, ":out_valid"},  64'(out_valid),  64'(m_hold));
    if (m_hold) chk({ph, ":out_product"}, out_product, m_prod);
  endtask

  // One clock: core model drives mul_result, edge, model update, then sample #1 after the edge
  task automatic step(input string ph);
    bit acc, cap, hs, launch;
    if (m_fly && (edge_n + 1 == m_launch + L)) mul_result = prod(m_a, m_b);
    else mul_result = {$urandom, $urandom};
    @(posedge clk);
    edge_n++;
    last_acc = 0;
    if (rst_n) begin
      acc    = in_valid && (q_a.size() < D);
      cap    = m_fly && (edge_n == m_launch + L);
      hs     = m_hold && out_ready;
      launch = (q_a.size() > 0) && ((!m_fly && !m_hold) || hs);
      if (hs) m_hold = 0;
      if (cap) begin
        m_fly = 0; m_hold = 1; m_prod = prod(m_a, m_b);
      end
      m_start = launch;
      if (launch) begin
        m_a = q_a.pop_front(); m_b = q_b.pop_front();
        m_fly = 1; m_launch = edge_n;
      end
      if (acc) begin
        q_a.push_back(in_a); q_b.push_back(in_b);
      end
      last_acc = acc;
    end
    #1;
    check_outputs(ph);
  endtask

  task automatic drain();
    int n;
    in_valid = 0; out_ready = 1; n = 0;
    while ((m_fly || m_hold || q_a.size() > 0) && n < 500) begin
      step("drain"); n++;
    end
    if (n >= 500) chk("drain_timeout", 64'd1, 64'd0);
  endtask

  task automatic run_one(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [63:0] exp);
    longint acc_edge;
    bit seen;
    drain();
    in_valid = 1; in_a = a; in_b = b;
    step(tag);
    acc_edge = edge_n;
    in_valid = 0; out_ready = 1; seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      step(tag);
      if (out_valid) seen = 1;
    end
    chk({tag, ":seen"},    64'(seen), 64'd1);
    chk({tag, ":latency"}, 64'(edge_n - acc_edge), 64'(L + 1));
    chk({tag, ":product"}, out_product, exp);
  endtask

  initial begin
    #100000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    model_reset();
    for (int i = 0; i < 3; i++) step("reset");
    chk("reset:out_product", out_product, 64'd0);
    #2 rst_n = 1;

    // single op and operand-hold/corner cases
    run_one("t1", 32'd7, -32'sd3, 64'hFFFF_FFFF_FFFF_FFEB);
    run_one("t4", 32'h1234_5678, 32'h0000_0010, 64'h0000_0001_2345_6780);
    run_one("c_min", 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
    run_one("c_neg1", 32'hFFFF_FFFF, 32'h0000_0001, 64'hFFFF_FFFF_FFFF_FFFF);
    run_one("c_zero", 32'h0000_0000, 32'h7FFF_FFFF, 64'd0);

    // fill: six back-to-back offers, the sixth meets a full FIFO
    drain();
    for (int i = 0; i < 6; i++) begin
      in_valid = 1; in_a = $urandom; in_b = $urandom;
      if (i == 5) begin
        chk("t2:full_ready", 64'(in_ready), 64'd0);
        chk("t2:full_count", 64'(fifo_count), 64'd4);
      end
      step("t2");
    end
    chk("t2:after_drop_count", 64'(fifo_count), 64'd4);
    drain();

    // backpressure
    out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1; in_a = $urandom; in_b = $urandom;
      step("t3");
    end
    in_valid = 0; seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      step("t3");
      if (out_valid) seen = 1;
    end
    chk("t3:seen", 64'(seen), 64'd1);
    for (int i = 0; i < 10; i++) begin
      step("t3_hold");
      chk("t3:no_start", 64'(mul_start), 64'd0);
    end
    out_ready = 1;
    step("t3");
    chk("t3:start_on_handshake", 64'(mul_start), 64'd1);
    drain();

    // reset in the middle of WAIT with two pairs queued
    for (int i = 0; i < 3; i++) begin
      in_valid = 1; in_a = $urandom; in_b = $urandom;
      step("t5");
    end
    in_valid = 0;
    for (int i = 0; i < 8; i++) step("t5");
    rst_n = 0;
    #1;
    model_reset();
    check_outputs("t5_rst");
    chk("t5:out_product", out_product, 64'd0);
    step("t5_rst");
    step("t5_rst");
    rst_n = 1;
    chk("t5:in_ready", 64'(in_ready), 64'd1);
    for (int i = 0; i < 60; i++) step("t5_idle");

    // randomised traffic
    for (int i = 0; i < 1500; i++) begin
      in_valid  = ($urandom_range(0, 1) == 1);
      out_ready = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 7))
        0: begin in_a = 32'h8000_0000; in_b = $urandom; end
        1: begin in_a = 32'hFFFF_FFFF; in_b = 32'h7FFF_FFFF; end
        default: begin in_a = $urandom; in_b = $urandom; end
      endcase
      step("rand");
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
